// File: rtl/minhash_pkg.sv
// Shared types and defaults for the MinHash top-K sorter.
// The optional MINHASH_DEDUP_EN feature is handled in minhash_topk_sorter.sv.
package minhash_pkg;

  localparam int DEF_SIGNATURE_WIDTH = 32;
  localparam int DEF_INDEX_WIDTH     = 10;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Slot entry at default widths; modules with overridden widths carry the
  // same three fields as separate ports.
  typedef struct packed {
    logic                           occupied;
    logic [DEF_SIGNATURE_WIDTH-1:0] signature;
    logic [DEF_INDEX_WIDTH-1:0]     index;
  } slot_t;

endpackage

// File: rtl/minhash_sort_cell.sv
// One slot of the sorted insertion array: holds an entry, reports whether it
// sorts after the incoming signature, and loads new/above/below on command.
module minhash_sort_cell
  import minhash_pkg::*;
#(
  parameter int SIGNATURE_WIDTH = DEF_SIGNATURE_WIDTH,
  parameter int INDEX_WIDTH     = DEF_INDEX_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       drain_step,
  input  logic                       shift_in,
  input  logic                       load_new,
  input  logic [SIGNATURE_WIDTH-1:0] in_signature,
  input  logic [INDEX_WIDTH-1:0]     in_index,
  input  logic                       above_occ,
  input  logic [SIGNATURE_WIDTH-1:0] above_sig,
  input  logic [INDEX_WIDTH-1:0]     above_idx,
  input  logic                       below_occ,
  input  logic [SIGNATURE_WIDTH-1:0] below_sig,
  input  logic [INDEX_WIDTH-1:0]     below_idx,
  output logic                       occ,
  output logic [SIGNATURE_WIDTH-1:0] sig,
  output logic [INDEX_WIDTH-1:0]     idx,
  output logic                       gt
);

  // Empty slots behave as +infinity; strict compare keeps equal keys stable.
  assign gt = ~occ | (sig > in_signature);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= 1'b0;
      sig <= '0;
      idx <= '0;
    end else if (clear) begin
      occ <= 1'b0;
      sig <= '0;
      idx <= '0;
    end else if (drain_step) begin
      occ <= below_occ;
      sig <= below_sig;
      idx <= below_idx;
    end else if (shift_in) begin
      occ <= above_occ;
      sig <= above_sig;
      idx <= above_idx;
    end else if (load_new) begin
      occ <= 1'b1;
      sig <= in_signature;
      idx <= in_index;
    end
  end

endmodule

// File: rtl/minhash_topk_sorter.sv
// Keeps the NUM_SLOTS smallest signatures of a set and drains their indices in
// ascending order. Define MINHASH_DEDUP_EN to drop signatures already held.
module minhash_topk_sorter
  import minhash_pkg::*;
#(
  parameter int SIGNATURE_WIDTH = DEF_SIGNATURE_WIDTH,
  parameter int INDEX_WIDTH     = DEF_INDEX_WIDTH,
  parameter int NUM_SLOTS       = 8,
  parameter int CNT_WIDTH       = $clog2(NUM_SLOTS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SIGNATURE_WIDTH-1:0] in_signature,
  input  logic [INDEX_WIDTH-1:0]     in_index,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SIGNATURE_WIDTH-1:0] out_signature,
  output logic [INDEX_WIDTH-1:0]     out_index,
  output logic                       out_last,
  output logic [CNT_WIDTH-1:0]       count,
  output logic                       evict,
  output logic                       dup_hit
);

  state_t                                    state;
  logic [NUM_SLOTS-1:0]                      occ;
  logic [NUM_SLOTS-1:0]                      gt;
  logic [NUM_SLOTS-1:0][SIGNATURE_WIDTH-1:0] sig;
  logic [NUM_SLOTS-1:0][INDEX_WIDTH-1:0]     idx;
  logic [CNT_WIDTH-1:0]                      ins_pos;
  logic                                      acc, dup, ins, full;
  logic                                      drain_hs, last_hs;

  assign acc      = in_valid & in_ready;
  assign ins      = acc & ~dup;
  assign full     = (count == CNT_WIDTH'(NUM_SLOTS));
  assign drain_hs = out_valid & out_ready;
  assign last_hs  = drain_hs & out_last;

  assign out_signature = sig[0];
  assign out_index     = idx[0];
  assign out_last      = out_valid & (count == CNT_WIDTH'(1));

`ifdef MINHASH_DEDUP_EN
  logic [NUM_SLOTS-1:0] eq;
  always_comb begin
    eq = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      eq[i] = occ[i] & (sig[i] == in_signature);
  end
  assign dup = |eq;
`else
  assign dup = 1'b0;
`endif

  // Lowest slot sorting after the incoming key; NUM_SLOTS means "past the end".
  always_comb begin
    ins_pos = CNT_WIDTH'(NUM_SLOTS);
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (gt[i]) ins_pos = CNT_WIDTH'(i);
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    logic                       a_occ, b_occ;
    logic [SIGNATURE_WIDTH-1:0] a_sig, b_sig;
    logic [INDEX_WIDTH-1:0]     a_idx, b_idx;

    if (g == 0) begin : g_first
      assign a_occ = 1'b0;
      assign a_sig = '0;
      assign a_idx = '0;
    end else begin : g_above
      assign a_occ = occ[g-1];
      assign a_sig = sig[g-1];
      assign a_idx = idx[g-1];
    end

    if (g == NUM_SLOTS - 1) begin : g_final
      assign b_occ = 1'b0;
      assign b_sig = '0;
      assign b_idx = '0;
    end else begin : g_below
      assign b_occ = occ[g+1];
      assign b_sig = sig[g+1];
      assign b_idx = idx[g+1];
    end

    minhash_sort_cell #(
      .SIGNATURE_WIDTH(SIGNATURE_WIDTH),
      .INDEX_WIDTH    (INDEX_WIDTH)
    ) u_cell (
      .clk         (clk),
      .rst         (rst),
      .clear       (last_hs),
      .drain_step  (drain_hs),
      .shift_in    (ins & (ins_pos < CNT_WIDTH'(g))),
      .load_new    (ins & (ins_pos == CNT_WIDTH'(g))),
      .in_signature(in_signature),
      .in_index    (in_index),
      .above_occ   (a_occ),
      .above_sig   (a_sig),
      .above_idx   (a_idx),
      .below_occ   (b_occ),
      .below_sig   (b_sig),
      .below_idx   (b_idx),
      .occ         (occ[g]),
      .sig         (sig[g]),
      .idx         (idx[g]),
      .gt          (gt[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      count     <= '0;
      evict     <= 1'b0;
      dup_hit   <= 1'b0;
    end else begin
      evict   <= 1'b0;
      dup_hit <= 1'b0;
      case (state)
        FILL: begin
          if (acc) begin
            dup_hit <= dup;
            // A full array always loses one entry: the old tail or the newcomer.
            if (!dup) begin
              if (full) evict <= 1'b1;
              else      count <= count + CNT_WIDTH'(1);
            end
            if (in_last) begin
              state     <= DRAIN;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_hs) begin
            if (out_last) begin
              state     <= FILL;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              count     <= '0;
            end else begin
              count <= count - CNT_WIDTH'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_minhash_topk_sorter.sv
// Scoreboard bench for minhash_topk_sorter: a sorted-list model queues the
// expected drain words as each set closes; the output monitor pops and compares.
module tb_minhash_topk_sorter;

  localparam int SW = 32;
  localparam int IW = 10;
  localparam int NS = 8;
  localparam int CW = $clog2(NS + 1);

  logic          clk, rst;
  logic          in_valid, in_ready, in_last;
  logic [SW-1:0] in_signature, out_signature;
  logic [IW-1:0] in_index, out_index;
  logic          out_valid, out_ready, out_last;
  logic [CW-1:0] count;
  logic          evict, dup_hit;

  minhash_topk_sorter #(
    .SIGNATURE_WIDTH(SW),
    .INDEX_WIDTH    (IW),
    .NUM_SLOTS      (NS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_signature (in_signature),
    .in_index     (in_index),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_signature(out_signature),
    .out_index    (out_index),
    .out_last     (out_last),
    .count        (count),
    .evict        (evict),
    .dup_hit      (dup_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [SW-1:0] s;
    logic [IW-1:0] i;
    logic          l;
  } exp_t;
  typedef struct packed {
    logic [SW-1:0] s;
    logic [IW-1:0] i;
  } ent_t;

  exp_t          sb[$];
  ent_t          model[$];
  logic [IW-1:0] drained_idx[$];

  int n_chk = 0, n_pass = 0;
  int evict_seen = 0, dup_seen = 0, exp_evict = 0, exp_dup = 0, hs_cnt = 0;
  logic          stall_pend = 1'b0;
  logic [SW+IW:0] stall_val;

  logic [SW-1:0] ref_sig [8] = '{32'h12345678, 32'h12345078, 32'h12045678, 32'h10345678,
                                 32'h12345178, 32'h12345278, 32'h12345628, 32'h12345670};
  logic [IW-1:0] ref_idx [8] = '{10'h201, 10'h101, 10'h081, 10'h041,
                                 10'h021, 10'h011, 10'h009, 10'h005};
  logic [IW-1:0] ref_ord [8] = '{10'h041, 10'h081, 10'h101, 10'h021,
                                 10'h011, 10'h009, 10'h005, 10'h201};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (evict)   evict_seen++;
      if (dup_hit) dup_seen++;
      if (stall_pend) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_stable", {out_signature, out_index, out_last}, stall_val);
      end
      if (out_valid) chk("in_ready_low", in_ready, 1'b0);
      stall_pend = out_valid & ~out_ready;
      stall_val  = {out_signature, out_index, out_last};
      if (out_valid && out_ready) begin
        hs_cnt++;
        drained_idx.push_back(out_index);
        chk("sb_nonempty", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("out_sig", out_signature, e.s);
          chk("out_idx", out_index, e.i);
          chk("out_last", out_last, e.l);
        end
      end
    end
  end

  // Drive one pair; model updated at acceptance, expected drain queued on last.
  task automatic push(input logic [SW-1:0] s, input logic [IW-1:0] i, input logic l);
    int  p, n;
    bit  d;
    ent_t en;
    in_valid = 1'b1; in_signature = s; in_index = i; in_last = l;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1'b1);
    d = 1'b0;
`ifdef MINHASH_DEDUP_EN
    foreach (model[k]) if (model[k].s == s) d = 1'b1;
`endif
    if (d) begin
      exp_dup++;
    end else begin
      p = model.size();
      for (int k = model.size() - 1; k >= 0; k--) if (model[k].s > s) p = k;
      en.s = s; en.i = i;
      model.insert(p, en);
      if (model.size() > NS) begin
        void'(model.pop_back());
        exp_evict++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    if (l) begin
      @(negedge clk);
      chk("drain_start_valid", out_valid, 1'b1);
      chk("drain_count", count, model.size());
      foreach (model[k]) sb.push_back({model[k].s, model[k].i, k == model.size() - 1});
      model.delete();
      @(posedge clk); #1;
    end
  endtask

  // mode 0: out_ready held high; mode 1: toggles every cycle.
  task automatic drain(input int mode, input int max_words);
    int start, cyc;
    start = hs_cnt; cyc = 0;
    while (hs_cnt - start < max_words && cyc < 200) begin
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    chk("drain_words", hs_cnt - start, max_words);
    if (mode == 0) chk("drain_rate", cyc, max_words);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_evicts"}, evict_seen, exp_evict);
    chk({tag, "_dups"}, dup_seen, exp_dup);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_signature = '0; in_index = '0;
    in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_evict", evict, 1'b0);
    chk("rst_dup_hit", dup_hit, 1'b0);
    chk("rst_out_data", {out_signature, out_index}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reference set, checked against the fixed expected order too.
    drained_idx.delete();
    for (int k = 0; k < 8; k++) push(ref_sig[k], ref_idx[k], k == 7);
    drain(0, 8);
    for (int k = 0; k < 8; k++) chk("ref_order", drained_idx[k], ref_order_at(k));
    idle_check("ref");

    // Overflow: larger 9th element discarded.
    drained_idx.delete();
    for (int k = 0; k < 8; k++) push(ref_sig[k], ref_idx[k], 1'b0);
    push(32'h9abcdef0, 10'h2AA, 1'b1);
    drain(0, 8);
    for (int k = 0; k < 8; k++) chk("ovf_order", drained_idx[k], ref_order_at(k));
    idle_check("ovf_big");
    chk("ovf_big_evicts", evict_seen, 1);

    // Overflow: new minimum pushes out the largest.
    for (int k = 0; k < 8; k++) push(ref_sig[k], ref_idx[k], 1'b0);
    push(32'h00000001, 10'h3FF, 1'b1);
    drain(0, 8);
    idle_check("ovf_small");
    chk("ovf_small_evicts", evict_seen, 2);

    // Short set.
    push(32'd5, 10'd1, 1'b0);
    push(32'd3, 10'd2, 1'b0);
    push(32'd9, 10'd3, 1'b1);
    chk("short_count", count, 3);
    drain(0, 3);
    idle_check("short");

    // Backpressure on the reference set.
    for (int k = 0; k < 8; k++) push(ref_sig[k], ref_idx[k], k == 7);
    drain(1, 8);
    idle_check("bp");

    // Duplicates.
    push(32'd7, 10'd1, 1'b0);
    push(32'd7, 10'd2, 1'b0);
    push(32'd2, 10'd3, 1'b1);
`ifdef MINHASH_DEDUP_EN
    drain(0, 2);
`else
    drain(0, 3);
`endif
    idle_check("dup");

    // Reset mid-drain.
    for (int k = 0; k < 5; k++) push(ref_sig[k], ref_idx[k], k == 4);
    drain(0, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_in_ready", in_ready, 1'b1);
    sb.delete(); model.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    push(32'h40, 10'h7, 1'b0);
    push(32'h10, 10'h8, 1'b0);
    push(32'h30, 10'h9, 1'b0);
    push(32'h20, 10'hA, 1'b1);
    drain(0, 4);
    idle_check("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  function automatic logic [IW-1:0] ref_order_at(input int k);
    return ref_ord[k];
  endfunction

endmodule

// File: doc/minhash_topk_sorter.md
# minhash_topk_sorter

Clocked, parametrised successor to the MinHash sorter. Streams (signature, index) pairs in one per cycle and keeps the NUM_SLOTS smallest signatures in a sorted insertion array. On end-of-set it drains the retained indices in ascending signature order over a valid/ready stream, then clears itself for the next set. Sits between the hash-signature generator and the sketch writer.

## Interface
- SIGNATURE_WIDTH, 32, signature bits
- INDEX_WIDTH, 10, element index bits
- NUM_SLOTS, 8, retained minima (K), >= 2
- CNT_WIDTH, $clog2(NUM_SLOTS+1), occupancy counter width (derived, do not override)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input pair valid
- in_ready  out  1  block accepts input (high only in FILL)
- in_signature  in  SIGNATURE_WIDTH  hash value
- in_index  in  INDEX_WIDTH  element index
- in_last  in  1  final element of current set
- out_valid  out  1  drain word valid
- out_ready  in  1  downstream accepts drain word
- out_signature  out  SIGNATURE_WIDTH  drained signature
- out_index  out  INDEX_WIDTH  drained index
- out_last  out  1  final drain word of set
- count  out  CNT_WIDTH  occupied slots
- evict  out  1  one-cycle pulse: an entry left the array because it was full
- dup_hit  out  1  one-cycle pulse: duplicate dropped (0 when feature compiled out)

## Operation
- Reset: all slots unoccupied, count=0, state FILL, in_ready=1, out_valid=0, out_last=0, evict=0, dup_hit=0, out_signature/out_index=0.
- States: FILL, DRAIN.
- FILL: on in_valid&in_ready, every slot compares in parallel; unoccupied slots count as +infinity. Insert position p = lowest slot whose stored signature > incoming (strict, unsigned). Slots p..N-2 shift to p+1..N-1; new pair written at p.
- Equal signatures: new entry goes after existing equal ones (stable).
- Array full, p < NUM_SLOTS: slot N-1 discarded, evict=1 next cycle. p = NUM_SLOTS (incoming >= all, full): incoming discarded, evict=1.
- count increments on insertion, saturates at NUM_SLOTS.
- Accept with in_last=1 -> DRAIN next cycle.
- DRAIN: in_ready=0; slot 0 presented on out_*; each out_valid&out_ready shifts array toward slot 0, count decrements. out_last=1 when count==1. Handshake on out_last -> all slots cleared, FILL.
- out_valid held and data stable while out_ready=0.
- Empty-set case impossible: in_last always carries an element, so DRAIN count >= 1.
- rst mid-set or mid-drain: immediate return to reset state; partial set lost, no out_last.

## Timing
- Insertion: 1 cycle; count reflects the accepted element on the following cycle.
- Back-to-back input at full rate in FILL.
- Accept of in_last at edge t -> out_valid=1 from cycle t+1 with the minimum.
- Drain throughput 1 word/cycle with out_ready held high; K words in K cycles.
- Final drain handshake at edge d -> in_ready=1 at cycle d+1.
- evict, dup_hit registered: assert in the cycle after the causing accept, for one cycle.

## Configuration
- MINHASH_DEDUP_EN defined: incoming signature equal to any occupied slot is dropped (no insert, count unchanged, no evict), dup_hit pulses.
- Undefined: equal signatures inserted per stable rule; dup_hit tied 0.

## Structure
- minhash_pkg: SIGNATURE_WIDTH/INDEX_WIDTH defaults, slot entry struct (occupied, signature, index), state enum {FILL, DRAIN}.
- Sub-module minhash_sort_cell: one slot; inputs neighbour-above entry, incoming pair, shift/insert/drain controls; outputs own entry and greater-than flag. Top instantiates NUM_SLOTS cells plus FSM and priority encoder.

## Test plan
- Reference set: 8 signatures 0x12345678, 0x12345078, 0x12045678, 0x10345678, 0x12345178, 0x12345278, 0x12345628, 0x12345670 (indices 0x201,0x101,0x081,0x041,0x021,0x011,0x009,0x005), last on 8th -> drain indices 0x041,0x081,0x101,0x021,0x011,0x009,0x005,0x201; out_last on 8th.
- Overflow: same set plus 9th 0x9abcdef0 (last) -> evict pulse on 9th, drain identical to above; then 0x00000001 idx 0x3FF inserted into full array -> drained first, 0x12345678 evicted.
- Short set: 3 elements 5,3,9 -> count=3, drain 3,5,9, out_last on 9.
- Backpressure: out_ready toggles 1/0 every cycle during drain -> no word lost or repeated, data stable while stalled, in_ready low until final handshake.
- Duplicates: 7,7,2 -> with MINHASH_DEDUP_EN drain 2,7 and one dup_hit; without drain 2,7,7 in arrival order.
- Reset mid-drain after 2 words -> out_valid=0, count=0, in_ready=1 next cycle; new set sorts correctly.
